// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder load/store slave.
package mem_resp_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that flags when it holds the value 1.
module wait_counter
    import mem_resp_pkg::*;
#(
    parameter int unsigned W = WAIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == W'(1));

endmodule

// File: rtl/mem_responder.sv
// Word-array memory responder with programmable wait states and valid/ready handshakes.
// Optional byte-lane store strobes (req_be) are enabled by defining MEM_RESP_BYTE_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
`ifdef MEM_RESP_BYTE_EN
    input  logic [WORD_BYTES-1:0] req_be,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t r_state;
    state_t w_next;

    logic                  r_write;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
`ifdef MEM_RESP_BYTE_EN
    logic [WORD_BYTES-1:0] r_be;
`endif
    logic                  r_ready;
    logic                  r_valid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_load;
    logic                  w_dec;
    logic                  w_access;
    logic                  w_cnt_done;
    logic                  w_bypass;
    logic                  w_a_write;
    logic [31:0]           w_a_addr;
    logic [31:0]           w_a_wdata;
    logic [WORD_BYTES-1:0] w_a_be;
    logic [32:0]           w_off;
    logic                  w_a_err;
    logic [IDX_W-1:0]      w_idx;

    wait_counter #(.W(WAIT_W)) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (WAIT_W'(WAIT_STATES)),
        .i_dec      (w_dec),
        .o_done     (w_cnt_done)
    );

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_access = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_next   = RESP;
                        w_access = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                w_dec = 1'b1;
                if (w_cnt_done) begin
                    w_next   = RESP;
                    w_access = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, so the
    // request fields are taken straight from the ports instead of the latches.
    always_comb begin
        w_bypass  = (r_state == IDLE);
        w_a_write = w_bypass ? req_write : r_write;
        w_a_addr  = w_bypass ? req_addr  : r_addr;
        w_a_wdata = w_bypass ? req_wdata : r_wdata;
`ifdef MEM_RESP_BYTE_EN
        w_a_be    = w_bypass ? req_be    : r_be;
`else
        w_a_be    = '1;
`endif
        // 33-bit difference: bit 32 is the borrow for addresses below the base
        w_off   = {1'b0, w_a_addr} - {1'b0, BASE_ADDR};
        w_a_err = (w_a_addr[1:0] != 2'b00) | w_off[32] | (|(w_off[31:0] >> (IDX_W + 2)));
        w_idx   = IDX_W'(w_off[31:0] >> 2);
    end

    always_ff @(posedge clk) begin
        if (w_access && w_a_write && !w_a_err) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (w_a_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef MEM_RESP_BYTE_EN
            r_be    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            r_valid <= (w_next == RESP);
            if (w_load) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef MEM_RESP_BYTE_EN
                r_be    <= req_be;
`endif
            end
            if (w_access) begin
                r_err   <= w_a_err;
                r_rdata <= (w_a_write || w_a_err) ? '0 : r_mem[w_idx];
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 uses 2 wait states, instance 1 uses none.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata[2];
    logic [31:0] rsp_rdata[2];
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]  req_be   [2];
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] e0, e1;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef MEM_RESP_BYTE_EN
        .req_be(req_be[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef MEM_RESP_BYTE_EN
        .req_be(req_be[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitors: pop the oldest expectation on every response handshake.
    always @(negedge clk) begin
        if (reset && rsp_valid[0] && rsp_ready[0]) begin
            if (exp_q0.size() == 0) begin
                timeout("rsp0 unexpected response");
            end else begin
                e0 = exp_q0.pop_front();
                chk("rsp0 rdata", rsp_rdata[0], e0[31:0]);
                chk("rsp0 err", {31'b0, rsp_err[0]}, {31'b0, e0[32]});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && rsp_valid[1] && rsp_ready[1]) begin
            if (exp_q1.size() == 0) begin
                timeout("rsp1 unexpected response");
            end else begin
                e1 = exp_q1.pop_front();
                chk("rsp1 rdata", rsp_rdata[1], e1[31:0]);
                chk("rsp1 err", {31'b0, rsp_err[1]}, {31'b0, e1[32]});
            end
        end
    end

    task automatic send(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        int t = 0;
        @(negedge clk);
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) timeout("req_ready wait");
        @(posedge clk);
        if (d == 0) exp_q0.push_back({exp_err, exp_rd});
        else        exp_q1.push_back({exp_err, exp_rd});
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hFFFF_FFF0;
        req_wdata[d] = 32'h5A5A_5A5A;
        req_write[d] = ~wr;
    endtask

    task automatic wait_valid(input int d, input int exp_lat);
        int lat = 1;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic xact(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        send(d, wr, addr, wdata, exp_rd, exp_err);
        wait_valid(d, exp_lat);
        @(posedge clk);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("reset req_ready", {31'b0, req_ready[d]}, 32'd1);
        chk("reset rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata[d], 32'd0);
        chk("reset rsp_err", {31'b0, rsp_err[d]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_write = '0;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
`ifdef MEM_RESP_BYTE_EN
            req_be[i]    = 4'b1111;
`endif
        end
        #12;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        reset = 1'b1;

        // basic store/load, misaligned and out-of-range requests
        xact(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0, 1'b0, 3);
        xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        xact(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        xact(0, 1'b0, 32'h0000_0012, 32'h0, 32'h0, 1'b1, 3);
        xact(0, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 3);
        xact(0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 1'b1, 3);
        xact(0, 1'b1, 32'h0000_0012, 32'hCAFE_F00D, 32'h0, 1'b1, 3);
        xact(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
        xact(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

        // response back-pressure
        #1 rsp_ready[0] = 1'b0;
        send(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_valid(0, 3);
        repeat (5) begin
            @(negedge clk);
            chk("hold rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("hold rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
            chk("hold req_ready", {31'b0, req_ready[0]}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("req_ready after handshake", {31'b0, req_ready[0]}, 32'd1);
        xact(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0, 3);

        // zero wait states
        xact(1, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 1'b0, 1);
        xact(1, 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 1'b0, 1);
        xact(1, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 1);

        // reset during WAIT aborts the pending store
        xact(0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0, 3);
        send(0, 1'b1, 32'h0000_0020, 32'h2222_2222, 32'h0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        void'(exp_q0.pop_back());
        #1 chk_reset_outputs(0);
        @(negedge clk);
        reset = 1'b1;
        xact(0, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0, 3);

        // reset during RESP clears the held load response immediately
        #1 rsp_ready[0] = 1'b0;
        send(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_valid(0, 3);
        chk("pre-reset rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
        #2 reset = 1'b0;
        void'(exp_q0.pop_back());
        #1 chk_reset_outputs(0);
        @(negedge clk);
        reset = 1'b1;

        // reset during RESP keeps the committed store
        send(0, 1'b1, 32'h0000_0030, 32'h3333_3333, 32'h0, 1'b0);
        wait_valid(0, 3);
        #2 reset = 1'b0;
        void'(exp_q0.pop_back());
        #1 chk("reset in RESP rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 rsp_ready[0] = 1'b1;
        xact(0, 1'b0, 32'h0000_0030, 32'h0, 32'h3333_3333, 1'b0, 3);

`ifdef MEM_RESP_BYTE_EN
        req_be[0] = 4'b1111;
        xact(0, 1'b1, 32'h0000_0000, 32'h1122_3344, 32'h0, 1'b0, 3);
        req_be[0] = 4'b0101;
        xact(0, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 32'h0, 1'b0, 3);
        req_be[0] = 4'b0000;
        xact(0, 1'b0, 32'h0000_0000, 32'h0, 32'h11BB_33DD, 1'b0, 3);
        xact(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 3);
        req_be[0] = 4'b1111;
        xact(0, 1'b0, 32'h0000_0000, 32'h0, 32'h11BB_33DD, 1'b0, 3);
`endif

        repeat (3) @(negedge clk);
        chk("queue0 drained", exp_q0.size(), 32'd0);
        chk("queue1 drained", exp_q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
